// File: rtl/jac1_pkg.sv
// jac1_pkg: shared state encodings and width defaults for the jac1 sequencer
package jac1_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE      = 3'd0;
  localparam state_t FETCH     = 3'd1;
  localparam state_t WAIT_MEM  = 3'd2;
  localparam state_t DECODE    = 3'd3;
  localparam state_t EXECUTE   = 3'd4;
  localparam state_t WRITEBACK = 3'd5;
  localparam state_t HALT      = 3'd6;
  localparam int CNT_WIDTH_DEF = 8;
  localparam int PC_WIDTH_DEF  = 8;
endpackage

// File: rtl/jac1_instr_counter.sv
// jac1_instr_counter: saturating up-counter (clk, res_n async low, en in; cnt out)
module jac1_instr_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) cnt <= '0;
    else if (en && !(&cnt)) cnt <= cnt + W'(1);
endmodule

// File: rtl/jac1_sequencer.sv
// jac1_sequencer: Moore fetch/decode/execute/writeback sequencer (clk, res_n, run, step_req, mem_ready, halt_op, branch_taken, clr_halt in; mem_req, ir_ld, rd_en, reg_wr_en, stat_wr_en, pc_inc, pc_ld, busy, halted, state, instr_cnt out); JAC1_SINGLE_STEP_EN enables step_req
module jac1_sequencer
  import jac1_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 run,
  input  logic                 step_req,
  input  logic                 mem_ready,
  input  logic                 halt_op,
  input  logic                 branch_taken,
  input  logic                 clr_halt,
  output logic                 mem_req,
  output logic                 ir_ld,
  output logic                 rd_en,
  output logic                 reg_wr_en,
  output logic                 stat_wr_en,
  output logic                 pc_inc,
  output logic                 pc_ld,
  output logic                 busy,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instr_cnt
);
  logic [2:0] nxt;
  logic br_q, step_q, go_step;
`ifdef JAC1_SINGLE_STEP_EN
  assign go_step = step_req && !run;
`else
  logic unused_step;
  assign unused_step = step_req;
  assign go_step = 1'b0;
`endif
  always_comb begin
    nxt = state == IDLE      ? ((run || go_step) ? FETCH : IDLE) :
          state == FETCH     ? (mem_ready ? DECODE : WAIT_MEM) :
          state == WAIT_MEM  ? (mem_ready ? DECODE : WAIT_MEM) :
          state == DECODE    ? (halt_op ? HALT : EXECUTE) :
          state == EXECUTE   ? WRITEBACK :
          state == WRITEBACK ? ((run && !step_q) ? FETCH : IDLE) :
          state == HALT      ? (clr_halt ? IDLE : HALT) : IDLE;
  end
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      state  <= IDLE;
      br_q   <= 1'b0;
      step_q <= 1'b0;
    end else begin
      state  <= nxt;
      br_q   <= state == EXECUTE ? branch_taken : br_q;
      step_q <= state == IDLE ? go_step : step_q;
    end
  assign mem_req    = state == FETCH || state == WAIT_MEM;
  assign ir_ld      = state == DECODE;
  assign rd_en      = state == DECODE || state == EXECUTE;
  assign reg_wr_en  = state == WRITEBACK;
  assign stat_wr_en = state == WRITEBACK;
  assign pc_inc     = state == WRITEBACK && !br_q;
  assign pc_ld      = state == WRITEBACK && br_q;
  assign busy       = state != IDLE && state != HALT && PC_WIDTH > 0;
  assign halted     = state == HALT;
  jac1_instr_counter #(.W(CNT_WIDTH)) u_cnt (
    .clk  (clk),
    .res_n(res_n),
    .en   (state == WRITEBACK),
    .cnt  (instr_cnt)
  );
endmodule

// File: tb/tb_jac1_sequencer.sv
// tb_jac1_sequencer: directed self-checking bench for jac1_sequencer
module tb_jac1_sequencer;
  logic clk = 0, res_n = 0, run = 0, step_req = 0, mem_ready = 0;
  logic halt_op = 0, branch_taken = 0, clr_halt = 0;
  logic mem_req, ir_ld, rd_en, reg_wr_en, stat_wr_en, pc_inc, pc_ld, busy, halted;
  logic [2:0] state;
  logic [7:0] instr_cnt;
  logic [1:0] sat_cnt;
  logic [11:0] sat_unused;
  logic [8:0] outs;
  int errors = 0, checks = 0, n_pc = 0, n_req = 0, n_ir = 0, n_wait = 0;
  logic [2:0] exp1 [13] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd1, 3'd3, 3'd4, 3'd5, 3'd1, 3'd3, 3'd4, 3'd5, 3'd0};
  assign outs = {mem_req, ir_ld, rd_en, reg_wr_en, stat_wr_en, pc_inc, pc_ld, busy, halted};
  always #5 clk = ~clk;
  jac1_sequencer dut (
    .clk(clk), .res_n(res_n), .run(run), .step_req(step_req), .mem_ready(mem_ready),
    .halt_op(halt_op), .branch_taken(branch_taken), .clr_halt(clr_halt),
    .mem_req(mem_req), .ir_ld(ir_ld), .rd_en(rd_en), .reg_wr_en(reg_wr_en),
    .stat_wr_en(stat_wr_en), .pc_inc(pc_inc), .pc_ld(pc_ld), .busy(busy),
    .halted(halted), .state(state), .instr_cnt(instr_cnt)
  );
  jac1_sequencer #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .res_n(res_n), .run(run), .step_req(step_req), .mem_ready(mem_ready),
    .halt_op(halt_op), .branch_taken(branch_taken), .clr_halt(clr_halt),
    .mem_req(sat_unused[0]), .ir_ld(sat_unused[1]), .rd_en(sat_unused[2]),
    .reg_wr_en(sat_unused[3]), .stat_wr_en(sat_unused[4]), .pc_inc(sat_unused[5]),
    .pc_ld(sat_unused[6]), .busy(sat_unused[7]), .halted(sat_unused[8]),
    .state(sat_unused[11:9]), .instr_cnt(sat_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    chk("pc_excl", 32'(pc_inc & pc_ld), 32'd0);
  endtask
  initial begin
    run = 1;
    mem_ready = 1;
    tick;
    tick;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'(outs), 32'd0);
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
    res_n = 1;
    for (int k = 0; k < 13; k++) begin
      tick;
      chk("run3_state", 32'(state), 32'(exp1[k]));
      n_pc += int'(pc_inc);
      if (k == 0) chk("run3_busy", 32'(busy), 32'd1);
      if (k == 9) run = 0;
    end
    chk("run3_pcinc", 32'(n_pc), 32'd3);
    chk("run3_cnt", 32'(instr_cnt), 32'd3);
    chk("run3_idle_busy", 32'(busy), 32'd0);
    chk("sat_cnt3", 32'(sat_cnt), 32'd3);
    mem_ready = 0;
    run = 1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      n_req += int'(mem_req);
      n_ir += int'(ir_ld);
      n_wait += int'(state == 3'd2);
      if (k == 4) begin
        mem_ready = 1;
        run = 0;
      end
    end
    chk("wait_cycles", 32'(n_wait), 32'd3);
    chk("wait_memreq", 32'(n_req), 32'd4);
    chk("wait_irld", 32'(n_ir), 32'd1);
    chk("wait_state", 32'(state), 32'd0);
    chk("wait_cnt", 32'(instr_cnt), 32'd4);
    chk("sat_hold", 32'(sat_cnt), 32'd3);
    run = 1;
    branch_taken = 1;
    tick;
    run = 0;
    tick;
    tick;
    tick;
    chk("br_state", 32'(state), 32'd5);
    chk("br_pcld", 32'(pc_ld), 32'd1);
    chk("br_pcinc", 32'(pc_inc), 32'd0);
    chk("br_regwr", 32'(reg_wr_en), 32'd1);
    branch_taken = 0;
    tick;
    chk("br_cnt", 32'(instr_cnt), 32'd5);
    chk("sat_cnt5", 32'(sat_cnt), 32'd3);
    run = 1;
    halt_op = 1;
    tick;
    run = 0;
    tick;
    tick;
    chk("halt_state", 32'(state), 32'd6);
    chk("halt_outs", 32'(outs), 32'd1);
    run = 1;
    step_req = 1;
    tick;
    run = 0;
    step_req = 0;
    halt_op = 0;
    chk("halt_sticky", 32'(state), 32'd6);
    chk("halt_cnt", 32'(instr_cnt), 32'd5);
    clr_halt = 1;
    tick;
    clr_halt = 0;
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_halted", 32'(halted), 32'd0);
    run = 1;
    tick;
    tick;
    tick;
    tick;
    chk("rstwb_pre", 32'(state), 32'd5);
    #2;
    res_n = 0;
    #1;
    chk("rstwb_state", 32'(state), 32'd0);
    chk("rstwb_outs", 32'(outs), 32'd0);
    chk("rstwb_cnt", 32'(instr_cnt), 32'd0);
    tick;
    chk("rstwb_hold", 32'(state), 32'd0);
    res_n = 1;
    tick;
    chk("rel_fetch", 32'(state), 32'd1);
    run = 0;
    tick;
    tick;
    tick;
    tick;
    chk("rel_idle", 32'(state), 32'd0);
    chk("rel_cnt", 32'(instr_cnt), 32'd1);
    step_req = 1;
    tick;
    step_req = 0;
`ifdef JAC1_SINGLE_STEP_EN
    chk("step_fetch", 32'(state), 32'd1);
    tick;
    run = 1;
    tick;
    tick;
    chk("step_wb", 32'(state), 32'd5);
    tick;
    run = 0;
    chk("step_idle", 32'(state), 32'd0);
    chk("step_cnt", 32'(instr_cnt), 32'd2);
`else
    chk("step_ign", 32'(state), 32'd0);
    tick;
    tick;
    chk("step_idle", 32'(state), 32'd0);
    chk("step_cnt", 32'(instr_cnt), 32'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
